// File: rtl/multi_channel_onehot_decoder_pkg.sv
// Shared constants and the one-hot helper for the multi-channel decoder.
package onehot_dec_pkg;

  localparam int SEL_W_DEF  = 4;
  localparam int N_OUT_DEF  = 16;
  localparam int N_CH_DEF   = 4;
  localparam int SEL_MAX    = 8;
  localparam int ONEHOT_MAX = 256;

  // Codes at or above n_out yield zero so they can never alias onto a legal line.
  function automatic logic [ONEHOT_MAX-1:0] onehot_f(input logic [SEL_MAX-1:0] sel,
                                                     input int n_out);
    logic [ONEHOT_MAX-1:0] v;
    v = '0;
    if (32'(sel) < 32'(n_out)) begin
      v[sel] = 1'b1;
    end else begin
      v = '0;
    end
    return v;
  endfunction

endpackage

// File: rtl/multi_channel_onehot_decoder_if.sv
// Request/result bundle of the multi-channel decoder; sticky signals exist only
// with ONEHOT_DEC_STICKY_EN.
interface multi_channel_onehot_decoder_if #(
  parameter int SEL_W = 4,
  parameter int N_OUT = 16,
  parameter int N_CH  = 4
) ();

  logic                    enable_i;
  logic [N_CH-1:0]         valid_i;
  logic [N_CH*SEL_W-1:0]   sel_i;
  logic [N_CH*N_OUT-1:0]   onehot_o;
  logic [N_OUT-1:0]        union_o;
  logic                    collision_o;
  logic [N_CH-1:0]         range_err_o;
`ifdef ONEHOT_DEC_STICKY_EN
  logic                    sticky_clr_i;
  logic [N_OUT-1:0]        sticky_o;
`endif

  modport master (
    output enable_i, valid_i, sel_i,
`ifdef ONEHOT_DEC_STICKY_EN
    output sticky_clr_i,
    input  sticky_o,
`endif
    input  onehot_o, union_o, collision_o, range_err_o
  );

  modport slave (
    input  enable_i, valid_i, sel_i,
`ifdef ONEHOT_DEC_STICKY_EN
    input  sticky_clr_i,
    output sticky_o,
`endif
    output onehot_o, union_o, collision_o, range_err_o
  );

endinterface

// File: rtl/multi_channel_onehot_decoder_ch.sv
// One decode channel: accept logic, range check, registered one-hot and range error.
module onehot_dec_ch
  import onehot_dec_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int N_OUT = N_OUT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable,
  input  logic             valid,
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] onehot_next,
  output logic [N_OUT-1:0] onehot_q,
  output logic             range_err_q
);

  // One extra bit so N_OUT == 2**SEL_W is still representable.
  localparam logic [SEL_W:0] LIMIT = (SEL_W+1)'(N_OUT);

  logic in_range_s;
  logic range_next_s;

  assign in_range_s = ({1'b0, sel} < LIMIT);

  // Next one-hot and range error for this channel.
  always_comb begin
    onehot_next  = '0;
    range_next_s = 1'b0;
    if (enable && valid && in_range_s) begin
      onehot_next = N_OUT'(onehot_f(SEL_MAX'(sel), N_OUT));
    end else if (enable && valid) begin
      range_next_s = 1'b1;
    end else begin
      onehot_next  = '0;
      range_next_s = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      onehot_q    <= '0;
      range_err_q <= 1'b0;
    end else begin
      onehot_q    <= onehot_next;
      range_err_q <= range_next_s;
    end
  end

endmodule

// File: rtl/multi_channel_onehot_decoder.sv
// N_CH-channel registered one-hot decoder with union, collision and range flags.
// Optional sticky hit mask enabled by ONEHOT_DEC_STICKY_EN.
module multi_channel_onehot_decoder
  import onehot_dec_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int N_OUT = N_OUT_DEF,
  parameter int N_CH  = N_CH_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  multi_channel_onehot_decoder_if.slave  bus
);

  logic [N_OUT-1:0] oh_next_s [N_CH];
  logic [N_OUT-1:0] oh_q_s    [N_CH];
  logic [N_CH-1:0]  range_q_s;
  logic [N_OUT-1:0] union_next_s;
  logic [N_OUT-1:0] dup_s;
  logic             collision_next_s;
  logic [N_OUT-1:0] union_r;
  logic             collision_r;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    onehot_dec_ch #(
      .SEL_W (SEL_W),
      .N_OUT (N_OUT)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .enable      (bus.enable_i),
      .valid       (bus.valid_i[c]),
      .sel         (bus.sel_i[c*SEL_W +: SEL_W]),
      .onehot_next (oh_next_s[c]),
      .onehot_q    (oh_q_s[c]),
      .range_err_q (range_q_s[c])
    );
  end

  // A line already seen from an earlier channel that is hit again is a collision.
  always_comb begin
    union_next_s = '0;
    dup_s        = '0;
    for (int c = 0; c < N_CH; c++) begin
      dup_s        = dup_s | (union_next_s & oh_next_s[c]);
      union_next_s = union_next_s | oh_next_s[c];
    end
    collision_next_s = |dup_s;
  end

  // Union and collision registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      union_r     <= '0;
      collision_r <= 1'b0;
    end else begin
      union_r     <= union_next_s;
      collision_r <= collision_next_s;
    end
  end

  // Pack the per-channel registers onto the flat output bus.
  always_comb begin
    bus.onehot_o = '0;
    for (int c = 0; c < N_CH; c++) begin
      bus.onehot_o[c*N_OUT +: N_OUT] = oh_q_s[c];
    end
  end

  assign bus.union_o     = union_r;
  assign bus.collision_o = collision_r;
  assign bus.range_err_o = range_q_s;

`ifdef ONEHOT_DEC_STICKY_EN
  logic [N_OUT-1:0] sticky_r;

  // A clear and a new hit in the same cycle keep the new hit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sticky_r <= '0;
    end else begin
      sticky_r <= (bus.sticky_clr_i ? '0 : sticky_r) | union_next_s;
    end
  end

  assign bus.sticky_o = sticky_r;
`endif

endmodule

// File: tb/tb_multi_channel_onehot_decoder.sv
// Directed self-checking bench: one 16-line and one 10-line decoder instance.
module tb_multi_channel_onehot_decoder;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  multi_channel_onehot_decoder_if #(.SEL_W(4), .N_OUT(16), .N_CH(4)) i16 ();
  multi_channel_onehot_decoder_if #(.SEL_W(4), .N_OUT(10), .N_CH(4)) i10 ();

  multi_channel_onehot_decoder #(.SEL_W(4), .N_OUT(16), .N_CH(4)) dut16 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (i16)
  );

  multi_channel_onehot_decoder #(.SEL_W(4), .N_OUT(10), .N_CH(4)) dut10 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (i10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [63:0] oh, input logic [15:0] un,
                       input logic co, input logic [3:0] re);
    chk({tag, "_oh16"}, 64'(i16.onehot_o), oh);
    chk({tag, "_un16"}, 64'(i16.union_o), 64'(un));
    chk({tag, "_co16"}, 64'(i16.collision_o), 64'(co));
    chk({tag, "_re16"}, 64'(i16.range_err_o), 64'(re));
  endtask

  task automatic chk10(input string tag, input logic [39:0] oh, input logic [9:0] un,
                       input logic co, input logic [3:0] re);
    chk({tag, "_oh10"}, 64'(i10.onehot_o), 64'(oh));
    chk({tag, "_un10"}, 64'(i10.union_o), 64'(un));
    chk({tag, "_co10"}, 64'(i10.collision_o), 64'(co));
    chk({tag, "_re10"}, 64'(i10.range_err_o), 64'(re));
  endtask

  initial begin
    logic [63:0] exp_oh;
    logic [15:0] exp_un;
    rst = 1'b1;
    i16.enable_i = 1'b0; i16.valid_i = 4'b0000; i16.sel_i = 16'h0000;
    i10.enable_i = 1'b0; i10.valid_i = 4'b0000; i10.sel_i = 16'h0000;
`ifdef ONEHOT_DEC_STICKY_EN
    i16.sticky_clr_i = 1'b0;
    i10.sticky_clr_i = 1'b0;
`endif
    cyc();
    chk16("reset", 64'h0, 16'h0, 1'b0, 4'b0000);
    chk10("reset", 40'h0, 10'h0, 1'b0, 4'b0000);
`ifdef ONEHOT_DEC_STICKY_EN
    chk("reset_sticky", 64'(i16.sticky_o), 64'h0);
`endif
    cyc();
    rst = 1'b0;

    // single channel decode
    i16.enable_i = 1'b1; i16.valid_i = 4'b0001; i16.sel_i = 16'h0005;
    cyc();
    chk16("ch0_sel5", 64'h0000_0000_0000_0020, 16'h0020, 1'b0, 4'b0000);

    // collision on line 3
    i16.valid_i = 4'b0011; i16.sel_i = 16'h0033;
    cyc();
    chk16("coll_3", 64'h0000_0000_0008_0008, 16'h0008, 1'b1, 4'b0000);

    i16.valid_i = 4'b0000;
    cyc();
    chk16("idle", 64'h0, 16'h0, 1'b0, 4'b0000);

    // non-adjacent collision, and invalid channels must not collide
    i16.valid_i = 4'b0101; i16.sel_i = 16'h0303;
    cyc();
    chk16("coll_02", 64'h0000_0008_0000_0008, 16'h0008, 1'b1, 4'b0000);
    i16.valid_i = 4'b0010; i16.sel_i = 16'h3333;
    cyc();
    chk16("no_coll_gated", 64'h0000_0000_0008_0000, 16'h0008, 1'b0, 4'b0000);
    i16.valid_i = 4'b0000;

    // out-of-range codes on the 10-line instance
    i10.enable_i = 1'b1; i10.valid_i = 4'b0001; i10.sel_i = 16'h000C;
    cyc();
    chk10("oor12", 40'h0, 10'h0, 1'b0, 4'b0001);
    i10.sel_i = 16'h0009;
    cyc();
    chk10("sel9", 40'h00_0000_0200, 10'h200, 1'b0, 4'b0000);
    i10.sel_i = 16'h000A;
    cyc();
    chk10("oor10", 40'h0, 10'h0, 1'b0, 4'b0001);
    i10.valid_i = 4'b0011; i10.sel_i = 16'h00CC;
    cyc();
    chk10("oor_pair", 40'h0, 10'h0, 1'b0, 4'b0011);
    i10.valid_i = 4'b0000;
    cyc();
    chk10("oor_pulse", 40'h0, 10'h0, 1'b0, 4'b0000);

    // enable low blocks everything, including range errors
    i16.enable_i = 1'b0; i16.valid_i = 4'b1111; i16.sel_i = 16'h1234;
    i10.enable_i = 1'b0; i10.valid_i = 4'b1111; i10.sel_i = 16'hCCCC;
    cyc();
    chk16("disabled", 64'h0, 16'h0, 1'b0, 4'b0000);
    chk10("disabled", 40'h0, 10'h0, 1'b0, 4'b0000);
    i10.valid_i = 4'b0000;

    // asynchronous reset in the middle of a burst
    i16.enable_i = 1'b1; i16.valid_i = 4'b1111; i16.sel_i = 16'h3210;
    cyc();
    chk16("burst", 64'h0008_0004_0002_0001, 16'h000F, 1'b0, 4'b0000);
    #2;
    rst = 1'b1;
    #1;
    chk16("async_rst", 64'h0, 16'h0, 1'b0, 4'b0000);
    cyc();
    rst = 1'b0;
    i16.valid_i = 4'b0000;

`ifdef ONEHOT_DEC_STICKY_EN
    chk("sticky_after_rst", 64'(i16.sticky_o), 64'h0);
    i16.valid_i = 4'b0001; i16.sel_i = 16'h0002;
    cyc();
    chk("sticky_2", 64'(i16.sticky_o), 64'h0004);
    i16.sel_i = 16'h0007;
    cyc();
    chk("sticky_27", 64'(i16.sticky_o), 64'h0084);
    i16.sticky_clr_i = 1'b1; i16.sel_i = 16'h0001;
    cyc();
    chk("sticky_clr_hit", 64'(i16.sticky_o), 64'h0002);
    i16.sticky_clr_i = 1'b0; i16.valid_i = 4'b0000;
    cyc();
    chk("sticky_hold", 64'(i16.sticky_o), 64'h0002);
`endif

    // sweep every code on every channel
    for (int c = 0; c < 4; c++) begin
      for (int s = 0; s < 16; s++) begin
        i16.valid_i = 4'(1 << c);
        i16.sel_i   = 16'(s << (4 * c));
        exp_oh      = 64'(1) << (c * 16 + s);
        exp_un      = 16'(1) << s;
        cyc();
        chk16("sweep", exp_oh, exp_un, 1'b0, 4'b0000);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
